// File: rtl/buffered_econet_ring.sv
// Econet receive ring: frames land in a byte ring, committed frames are announced as descriptors.
// Define ECONET_RXBUF_STATS_EN to add saturating drop/overflow statistics counters.
module buffered_econet_ring #(
    parameter int unsigned BUF_BYTES = 2048,
    parameter int unsigned PTR_WIDTH = 11,
    parameter int unsigned NDESC     = 4,
    parameter logic [15:0] FCS_GOOD  = 16'hF0B8
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_byte_ready,
    input  logic                 rx_frame_start,
    input  logic                 rx_frame_end,
    input  logic [15:0]          rx_fcs,
    input  logic                 sys_rd,
    input  logic [PTR_WIDTH-3:0] sys_addr,
    output logic [31:0]          sys_data,
    output logic                 desc_valid,
    output logic [PTR_WIDTH-1:0] desc_start,
    output logic [PTR_WIDTH:0]   desc_len,
    input  logic                 desc_pop,
    output logic                 receiving
`ifdef ECONET_RXBUF_STATS_EN
    ,
    output logic [7:0]           stat_fcs_err,
    output logic [7:0]           stat_overflow,
    output logic [7:0]           stat_nodesc
`endif
);

    localparam int unsigned WORDS  = BUF_BYTES / 4;
    localparam int unsigned DIDX_W = (NDESC > 1) ? $clog2(NDESC) : 1;
    localparam int unsigned CW     = DIDX_W + 1;
    localparam logic [PTR_WIDTH:0] BUF_SIZE = (PTR_WIDTH + 1)'(BUF_BYTES);

    typedef enum logic [1:0] {StIdle, StRecv, StDiscard} state_t;

    state_t               state;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] commit_ptr;
    logic [PTR_WIDTH:0]   used;
    logic [PTR_WIDTH:0]   len;

    logic [31:0]          mem [WORDS];
    logic [PTR_WIDTH-1:0] fifo_start [NDESC];
    logic [PTR_WIDTH:0]   fifo_len [NDESC];
    logic [DIDX_W-1:0]    rd_idx;
    logic [DIDX_W-1:0]    wr_idx;
    logic [CW-1:0]        count;

    logic                 in_recv;
    logic                 full;
    logic                 byte_ok;
    logic                 overflow;
    logic                 end_ev;
    logic                 fcs_ok;
    logic                 fifo_full;
    logic                 commit;
    logic                 pop;
    logic [PTR_WIDTH:0]   len_eff;
    logic [PTR_WIDTH-1:0] wr_ptr_nxt;
    logic [PTR_WIDTH:0]   used_nxt;

    assign desc_valid = (count != '0);
    assign desc_start = fifo_start[rd_idx];
    assign desc_len   = fifo_len[rd_idx];

    // A frame_start in the same cycle overrides any byte or end strobe of the old frame.
    always_comb begin
        in_recv    = (state == StRecv) && !rx_frame_start;
        full       = (used + len) >= BUF_SIZE;
        byte_ok    = in_recv && rx_byte_ready && !full;
        overflow   = in_recv && rx_byte_ready && full;
        end_ev     = in_recv && rx_frame_end;
        fcs_ok     = (rx_fcs == FCS_GOOD);
        fifo_full  = (count == CW'(NDESC));
        len_eff    = len + (PTR_WIDTH + 1)'(byte_ok);
        commit     = end_ev && !overflow && fcs_ok && (len_eff != '0) && !fifo_full;
        pop        = desc_pop && desc_valid;
        wr_ptr_nxt = byte_ok ? wr_ptr + 1'b1 : wr_ptr;
        used_nxt   = used + (commit ? len_eff : '0) - (pop ? desc_len : '0);
    end

    always_ff @(posedge sys_clk) begin
        if (byte_ok) begin
            mem[wr_ptr[PTR_WIDTH-1:2]][{wr_ptr[1:0], 3'b000} +: 8] <= rx_byte;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (commit) begin
            fifo_start[wr_idx] <= commit_ptr;
            fifo_len[wr_idx]   <= len_eff;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sys_data <= '0;
        end else if (sys_rd) begin
            sys_data <= mem[sys_addr];
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            receiving  <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            used       <= '0;
            len        <= '0;
            rd_idx     <= '0;
            wr_idx     <= '0;
            count      <= '0;
        end else begin
            used   <= used_nxt;
            count  <= count + CW'(commit) - CW'(pop);
            wr_ptr <= wr_ptr_nxt;
            if (byte_ok) begin
                len <= len + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (commit) begin
                wr_idx     <= wr_idx + 1'b1;
                commit_ptr <= wr_ptr_nxt;
            end
            case (state)
                StIdle: begin
                    if (rx_frame_start) begin
                        state     <= StRecv;
                        receiving <= 1'b1;
                        wr_ptr    <= commit_ptr;
                        len       <= '0;
                    end
                end
                StRecv, StDiscard: begin
                    if (rx_frame_start) begin
                        // Abort: anything written past commit_ptr is simply reused.
                        state     <= StRecv;
                        receiving <= 1'b1;
                        wr_ptr    <= commit_ptr;
                        len       <= '0;
                    end else if (overflow && !rx_frame_end) begin
                        state <= StDiscard;
                    end else if (rx_frame_end) begin
                        state     <= StIdle;
                        receiving <= 1'b0;
                        len       <= '0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    receiving <= 1'b0;
                end
            endcase
        end
    end

`ifdef ECONET_RXBUF_STATS_EN
    logic fcs_drop;
    logic nodesc_drop;

    assign fcs_drop    = end_ev && !overflow && !fcs_ok;
    assign nodesc_drop = end_ev && !overflow && fcs_ok && (len_eff != '0) && fifo_full;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            stat_fcs_err  <= '0;
            stat_overflow <= '0;
            stat_nodesc   <= '0;
        end else begin
            if (fcs_drop && stat_fcs_err != 8'hFF) begin
                stat_fcs_err <= stat_fcs_err + 1'b1;
            end
            if (overflow && stat_overflow != 8'hFF) begin
                stat_overflow <= stat_overflow + 1'b1;
            end
            if (nodesc_drop && stat_nodesc != 8'hFF) begin
                stat_nodesc <= stat_nodesc + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_buffered_econet_ring.sv
// Bench for buffered_econet_ring: frame-level reference model feeding a descriptor scoreboard.
module tb_buffered_econet_ring;

    localparam int BUF = 64;
    localparam int PW  = 6;
    localparam int ND  = 4;
    localparam logic [15:0] GOOD = 16'hF0B8;

    logic          sys_clk;
    logic          reset;
    logic [7:0]    rx_byte;
    logic          rx_byte_ready;
    logic          rx_frame_start;
    logic          rx_frame_end;
    logic [15:0]   rx_fcs;
    logic          sys_rd;
    logic [PW-3:0] sys_addr;
    logic [31:0]   sys_data;
    logic          desc_valid;
    logic [PW-1:0] desc_start;
    logic [PW:0]   desc_len;
    logic          desc_pop;
    logic          receiving;
`ifdef ECONET_RXBUF_STATS_EN
    logic [7:0]    stat_fcs_err;
    logic [7:0]    stat_overflow;
    logic [7:0]    stat_nodesc;
`endif

    buffered_econet_ring #(
        .BUF_BYTES(BUF),
        .PTR_WIDTH(PW),
        .NDESC    (ND),
        .FCS_GOOD (GOOD)
    ) dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .rx_byte       (rx_byte),
        .rx_byte_ready (rx_byte_ready),
        .rx_frame_start(rx_frame_start),
        .rx_frame_end  (rx_frame_end),
        .rx_fcs        (rx_fcs),
        .sys_rd        (sys_rd),
        .sys_addr      (sys_addr),
        .sys_data      (sys_data),
        .desc_valid    (desc_valid),
        .desc_start    (desc_start),
        .desc_len      (desc_len),
        .desc_pop      (desc_pop),
        .receiving     (receiving)
`ifdef ECONET_RXBUF_STATS_EN
        ,
        .stat_fcs_err  (stat_fcs_err),
        .stat_overflow (stat_overflow),
        .stat_nodesc   (stat_nodesc)
`endif
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference model: a list of pending frames plus the byte image of the ring.
    typedef struct packed {
        int start;
        int len;
    } desc_t;

    desc_t      m_q[$];
    logic [7:0] m_ring [BUF];
    bit         m_in = 0;
    bit         m_disc = 0;
    int         m_len = 0;
    int         m_commit = 0;
    int         m_gen = 0;
    int         s_fcs = 0;
    int         s_ovf = 0;
    int         s_nodesc = 0;
    int         pop_budget = 0;
    int         pops_done = 0;
    bit         chk_on = 0;

    function automatic int used_sum();
        int s = 0;
        foreach (m_q[i]) s += m_q[i].len;
        return s;
    endfunction

    initial begin
        int    pre_n;
        int    pre_used;
        bit    do_pop;
        desc_t d;
        forever begin
            @(posedge sys_clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_in = 0; m_disc = 0; m_len = 0; m_commit = 0;
                s_fcs = 0; s_ovf = 0; s_nodesc = 0;
                m_gen++;
            end else begin
                pre_n    = m_q.size();
                pre_used = used_sum();
                do_pop   = desc_pop && (pre_n > 0);
                if (rx_frame_start) begin
                    m_in = 1; m_disc = 0; m_len = 0;
                end else if (m_in && !m_disc) begin
                    if (rx_byte_ready) begin
                        if (pre_used + m_len < BUF) begin
                            m_ring[(m_commit + m_len) % BUF] = rx_byte;
                            m_len++;
                        end else begin
                            m_disc = 1;
                            if (s_ovf < 255) s_ovf++;
                        end
                    end
                    if (rx_frame_end) begin
                        if (!m_disc) begin
                            if (rx_fcs != GOOD) begin
                                if (s_fcs < 255) s_fcs++;
                            end else if (m_len > 0) begin
                                if (pre_n >= ND) begin
                                    if (s_nodesc < 255) s_nodesc++;
                                end else begin
                                    d.start = m_commit;
                                    d.len   = m_len;
                                    m_q.push_back(d);
                                    m_commit = (m_commit + m_len) % BUF;
                                end
                            end
                        end
                        m_in = 0; m_disc = 0;
                    end
                end else if (m_in && m_disc) begin
                    if (rx_frame_end) begin
                        m_in = 0; m_disc = 0;
                    end
                end
                if (do_pop) void'(m_q.pop_front());
            end
        end
    end

    // Per-cycle status comparison against the model.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (chk_on) begin
                check("receiving", receiving, m_in);
                check("desc_valid", desc_valid, m_q.size() > 0);
`ifdef ECONET_RXBUF_STATS_EN
                check("stat_fcs_err", stat_fcs_err, s_fcs);
                check("stat_overflow", stat_overflow, s_ovf);
                check("stat_nodesc", stat_nodesc, s_nodesc);
`endif
            end
        end
    end

    // Scoreboard monitor: checks the head descriptor and its bytes, then pops it.
    initial begin
        desc_t d;
        int    g;
        int    o;
        sys_rd   = 1'b0;
        sys_addr = '0;
        desc_pop = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (chk_on && !reset && pop_budget > pops_done && desc_valid && m_q.size() > 0) begin
                g = m_gen;
                d = m_q[0];
                check("desc_start", desc_start, d.start);
                check("desc_len", desc_len, d.len);
                for (int i = 0; i < d.len; i++) begin
                    o        = (d.start + i) % BUF;
                    sys_rd   = 1'b1;
                    sys_addr = PW'(o) >> 2;
                    @(posedge sys_clk);
                    #1;
                    sys_rd = 1'b0;
                    if (g != m_gen) break;
                    check("ring_byte", sys_data[8*(o%4) +: 8], m_ring[o]);
                end
                if (g == m_gen) begin
                    desc_pop = 1'b1;
                    @(posedge sys_clk);
                    #1;
                    desc_pop = 1'b0;
                    pops_done++;
                end
            end
        end
    end

    task automatic cyc(input bit st, input bit bv, input logic [7:0] b, input bit en,
                       input logic [15:0] f);
        rx_frame_start = st;
        rx_byte_ready  = bv;
        rx_byte        = b;
        rx_frame_end   = en;
        rx_fcs         = f;
        @(negedge sys_clk);
        rx_frame_start = 1'b0;
        rx_byte_ready  = 1'b0;
        rx_frame_end   = 1'b0;
    endtask

    task automatic send(input int n, input logic [15:0] f, input bit coinc, input bit seq,
                        input int max_gap);
        logic [7:0] b;
        cyc(1, 0, 8'h00, 0, 16'h0);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge sys_clk);
            b = seq ? 8'(i + 1) : 8'($urandom);
            cyc(0, 1, b, coinc && (i == n - 1), f);
        end
        if (!coinc || n == 0) cyc(0, 0, 8'h00, 1, f);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;
        pop_budget = pops_done;
    endtask

    task automatic wait_pops(input int target);
        int k = 0;
        while (pops_done < target && k < 500) begin
            @(negedge sys_clk);
            k++;
        end
        check("pop_wait", pops_done, target);
    endtask

    task automatic drain();
        int k = 0;
        pop_budget = pops_done + 100000;
        while (m_q.size() > 0 && k < 3000) begin
            @(negedge sys_clk);
            k++;
        end
        check("drain", m_q.size(), 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        pop_budget = pops_done;
    endtask

    initial begin
        int n;
        logic [15:0] f;
        reset = 1'b1;
        rx_byte = '0; rx_byte_ready = 0; rx_frame_start = 0; rx_frame_end = 0; rx_fcs = '0;
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        chk_on = 1;
        check("rst_sys_data", sys_data, 0);
        check("rst_desc_valid", desc_valid, 0);
        check("rst_receiving", receiving, 0);

        // Basic good frame 01..05.
        send(5, GOOD, 0, 1, 0);
        check("basic_start", desc_start, 0);
        check("basic_len", desc_len, 5);
        drain();

        // Bad FCS rolls back; next good frame reuses offset 0.
        do_reset();
        send(5, 16'h1234, 0, 1, 0);
        check("badfcs_valid", desc_valid, 0);
        send(5, GOOD, 0, 1, 1);
        check("rollback_start", desc_start, 0);
        check("rollback_len", desc_len, 5);
        drain();

        // Overflow into DISCARD.
        do_reset();
        send(70, GOOD, 0, 0, 0);
        check("ovf_valid", desc_valid, 0);
        send(3, GOOD, 0, 0, 0);
        check("ovf_next_start", desc_start, 0);
        check("ovf_next_len", desc_len, 3);
        drain();

        // Descriptor FIFO full: fifth frame dropped.
        do_reset();
        for (int i = 0; i < 5; i++) send(4, GOOD, 0, 0, 0);
        check("full_start", desc_start, 0);
        check("full_len", desc_len, 4);
        pop_budget = pops_done + 1;
        wait_pops(pop_budget);
        @(negedge sys_clk);
        check("after_pop_start", desc_start, 4);
        check("after_pop_len", desc_len, 4);
        drain();

        // Wrap around the ring end.
        do_reset();
        send(56, GOOD, 0, 0, 0);
        send(4, GOOD, 0, 0, 0);
        pop_budget = pops_done + 1;
        wait_pops(pop_budget);
        send(10, GOOD, 0, 1, 0);
        check("wrap_head_start", desc_start, 56);
        pop_budget = pops_done + 1;
        wait_pops(pop_budget);
        @(negedge sys_clk);
        check("wrap_start", desc_start, 60);
        check("wrap_len", desc_len, 10);
        drain();

        // Byte coincident with frame end.
        do_reset();
        send(3, GOOD, 1, 1, 0);
        check("coinc_len", desc_len, 3);
        drain();

        // Reset mid-frame.
        cyc(1, 0, 8'h00, 0, 16'h0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'($urandom), 0, 16'h0);
        check("midrst_recv_before", receiving, 1);
        do_reset();
        check("midrst_recv", receiving, 0);
        check("midrst_valid", desc_valid, 0);

        // Randomized traffic with free-running pops.
        pop_budget = pops_done + 100000;
        for (int fr = 0; fr < 40; fr++) begin
            n = $urandom_range(20, 0);
            f = ($urandom_range(9, 0) < 8) ? GOOD : 16'($urandom);
            if ($urandom_range(7, 0) == 0) begin
                cyc(1, 0, 8'h00, 0, 16'h0);
                for (int i = 0; i < n; i++) cyc(0, 1, 8'($urandom), 0, 16'h0);
            end else begin
                send(n, f, 1'($urandom_range(1, 0)), 0, 2);
            end
            repeat ($urandom_range(4, 0)) @(negedge sys_clk);
        end
        cyc(0, 0, 8'h00, 1, GOOD);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
